hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RV32I core. Watches ID/EX/MEM-stage status and drives the stall and flush enables of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It complements the EX-stage operand forwarding logic by handling what forwarding cannot:
- load-use hazards
- taken branch/jump redirects, including the wrong-path slot of the synchronous instruction memory
- data-memory wait states, with a timeout

---
 rtl/hazard_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for the five-stage RV32I core. It drives the
//   stall/flush enables of the PC and pipeline registers for the cases that
//   EX-stage forwarding cannot resolve:
//     - load-use hazards (one bubble),
//     - taken branch/jump redirects (EX-cycle flush plus one REFILL slot that
//       kills the wrong-path fetch of the synchronous instruction memory),
//     - data-memory wait states, aborted after MEM_TIMEOUT waiting cycles.
//
//   Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
//   stall/flush performance counters; otherwise both count outputs are 0.
//
// Parameters
//   MEM_TIMEOUT  max consecutive cycles waiting on dmem_ready (>= 2)
//   CNT_WIDTH    width of the performance counters
//
// Ports
//   clk, rst                    core clock, synchronous active-high reset
//   mem_read_ex, rd_addr_ex     EX instruction is a load / its destination
//   rs1/rs2_addr_id, _used_id   ID source registers and whether they are read
//   redirect_ex                 taken branch or JAL/JALR resolved in EX
//   dmem_req_mem, dmem_ready    MEM-stage access active / completes this cycle
//   *_stall                     hold PC / IF-ID / ID-EX / EX-MEM
//   *_flush                     load a bubble into IF-ID / ID-EX / MEM-WB
//   mem_err                     one-cycle pulse after a dmem timeout
//   stall_cnt, flush_cnt        performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_read_ex,
   input  logic [4:0]           rd_addr_ex,
   input  logic [4:0]           rs1_addr_id,
   input  logic [4:0]           rs2_addr_id,
   input  logic                 rs1_used_id,
   input  logic                 rs2_used_id,
   input  logic                 redirect_ex,
   input  logic                 dmem_req_mem,
   input  logic                 dmem_ready,
   output logic                 pc_stall,
   output logic                 if_id_stall,
   output logic                 id_ex_stall,
   output logic                 ex_mem_stall,
   output logic                 if_id_flush,
   output logic                 id_ex_flush,
   output logic                 mem_wb_flush,
   output logic                 mem_err,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, REFILL, MEM_WAIT} state_t;

   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   state_t          state, state_nxt;
   logic [TW-1:0]   tmo_cnt, tmo_nxt;
   logic            err_nxt;
   logic            freeze;
   logic            load_use;
   logic            mem_wait;

   assign load_use = mem_read_ex && (rd_addr_ex != 5'd0) &&
                     ((rs1_used_id && (rs1_addr_id == rd_addr_ex)) ||
                      (rs2_used_id && (rs2_addr_id == rd_addr_ex)));

   assign mem_wait = dmem_req_mem && !dmem_ready;

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt    = state;
      tmo_nxt      = tmo_cnt;
      err_nxt      = 1'b0;
      freeze       = 1'b0;
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_stall  = 1'b0;
      ex_mem_stall = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;

      if (rst) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         mem_wb_flush = 1'b1;
         state_nxt    = RUN;
         tmo_nxt      = '0;
      end else begin
         unique case (state)
            RUN: begin
               if (mem_wait) begin
                  freeze    = 1'b1;
                  state_nxt = MEM_WAIT;
                  tmo_nxt   = TW'(1);
               end else if (redirect_ex) begin
                  // ID holds a wrong-path instruction, so load-use is moot.
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  state_nxt   = REFILL;
               end else if (load_use) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
               end
            end

            REFILL: begin
               if (mem_wait) begin
                  // IF/ID is held with the bubble loaded last cycle, so the
                  // wrong-path fetch never enters the pipe and no second
                  // REFILL is owed.
                  freeze    = 1'b1;
                  state_nxt = MEM_WAIT;
                  tmo_nxt   = TW'(1);
               end else begin
                  if_id_flush = 1'b1;
                  state_nxt   = RUN;
               end
            end

            MEM_WAIT: begin
               if (dmem_ready) begin
                  state_nxt = RUN;
                  tmo_nxt   = '0;
               end else if (tmo_cnt == TW'(MEM_TIMEOUT - 1)) begin
                  // Last allowed waiting cycle: let the stuck access leave
                  // MEM as a bubble and report the abort next cycle.
                  mem_wb_flush = 1'b1;
                  err_nxt      = 1'b1;
                  state_nxt    = RUN;
                  tmo_nxt      = '0;
               end else begin
                  freeze  = 1'b1;
                  tmo_nxt = tmo_cnt + TW'(1);
               end
            end

            default: begin
               state_nxt = RUN;
               tmo_nxt   = '0;
            end
         endcase
      end

      if (freeze) begin
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
         mem_wb_flush = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RUN;
         tmo_cnt <= '0;
         mem_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         tmo_cnt <= tmo_nxt;
         mem_err <= err_nxt;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] stall_q, flush_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (pc_stall && (stall_q != '1))
            stall_q <= stall_q + 1'b1;
         if ((if_id_flush || id_ex_flush) && (flush_q != '1))
            flush_q <= flush_q + 1'b1;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT = 4). Each cycle
//   the inputs are driven just after the rising edge, and the combinational
//   controls plus the registered mem_err are compared at the falling edge
//   against hand-computed vectors. Control vector bit order:
//   {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
//    if_id_flush, id_ex_flush, mem_wb_flush}
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_read_ex;
   logic [4:0]    rd_addr_ex;
   logic [4:0]    rs1_addr_id;
   logic [4:0]    rs2_addr_id;
   logic          rs1_used_id;
   logic          rs2_used_id;
   logic          redirect_ex;
   logic          dmem_req_mem;
   logic          dmem_ready;
   logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
   logic          if_id_flush, id_ex_flush, mem_wb_flush;
   logic          mem_err;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int total = 0;
   int bad   = 0;
   logic [CW-1:0] exp_stall_cnt = '0;
   logic [CW-1:0] exp_flush_cnt = '0;

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_read_ex  (mem_read_ex),
      .rd_addr_ex   (rd_addr_ex),
      .rs1_addr_id  (rs1_addr_id),
      .rs2_addr_id  (rs2_addr_id),
      .rs1_used_id  (rs1_used_id),
      .rs2_used_id  (rs2_used_id),
      .redirect_ex  (redirect_ex),
      .dmem_req_mem (dmem_req_mem),
      .dmem_ready   (dmem_ready),
      .pc_stall     (pc_stall),
      .if_id_stall  (if_id_stall),
      .id_ex_stall  (id_ex_stall),
      .ex_mem_stall (ex_mem_stall),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .mem_wb_flush (mem_wb_flush),
      .mem_err      (mem_err),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      mem_read_ex  = 1'b0;
      rd_addr_ex   = 5'd0;
      rs1_addr_id  = 5'd0;
      rs2_addr_id  = 5'd0;
      rs1_used_id  = 1'b0;
      rs2_used_id  = 1'b0;
      redirect_ex  = 1'b0;
      dmem_req_mem = 1'b0;
      dmem_ready   = 1'b0;
   endtask

   task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2);
      mem_read_ex = 1'b1;
      rd_addr_ex  = rd;
      rs1_addr_id = rs1;
      rs1_used_id = u1;
      rs2_addr_id = rs2;
      rs2_used_id = u2;
   endtask

   // Check one cycle with the inputs already applied, then advance.
   task automatic cyc(input string tag, input logic [6:0] exp_ctl, input logic exp_err);
      logic [6:0] ctl;
      @(negedge clk);
      ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
             if_id_flush, id_ex_flush, mem_wb_flush};
      check({tag, ".ctl"}, {25'd0, ctl}, {25'd0, exp_ctl});
      check({tag, ".err"}, {31'd0, mem_err}, {31'd0, exp_err});
`ifdef HAZARD_PERF_CNT_EN
      check({tag, ".stall_cnt"}, stall_cnt, exp_stall_cnt);
      check({tag, ".flush_cnt"}, flush_cnt, exp_flush_cnt);
`else
      check({tag, ".cnt_tied"}, stall_cnt | flush_cnt, 32'd0);
`endif
      if (rst) begin
         exp_stall_cnt = '0;
         exp_flush_cnt = '0;
      end else begin
         if (exp_ctl[6]) exp_stall_cnt = exp_stall_cnt + 1;
         if (exp_ctl[2] || exp_ctl[1]) exp_flush_cnt = exp_flush_cnt + 1;
      end
      @(posedge clk);
      #1;
   endtask

   localparam logic [6:0] NONE   = 7'b0000_000;
   localparam logic [6:0] RSTV   = 7'b0000_111;
   localparam logic [6:0] LUSE   = 7'b1100_010;
   localparam logic [6:0] REDIR  = 7'b0000_110;
   localparam logic [6:0] REFL   = 7'b0000_100;
   localparam logic [6:0] FRZ    = 7'b1111_001;
   localparam logic [6:0] ABORT  = 7'b0000_001;

   initial begin
      idle_inputs();
      rst = 1'b1;
      cyc("reset0", RSTV, 1'b0);
      cyc("reset1", RSTV, 1'b0);
      rst = 1'b0;
      cyc("idle", NONE, 1'b0);

      // Load-use on rs1: exactly one bubble.
      set_load(5'd5, 5'd5, 1'b1, 5'd9, 1'b1);
      cyc("luse_rs1", LUSE, 1'b0);
      idle_inputs();
      cyc("luse_after", NONE, 1'b0);

      // rd = x0 never stalls.
      set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      cyc("luse_x0", NONE, 1'b0);

      // rs2 match counts only when rs2 is actually read.
      set_load(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
      cyc("luse_rs2", LUSE, 1'b0);
      set_load(5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
      cyc("luse_rs2_unused", NONE, 1'b0);
      idle_inputs();

      // Redirect in RUN with load-use present: redirect wins, then REFILL.
      redirect_ex = 1'b1;
      set_load(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
      cyc("redir", REDIR, 1'b0);
      redirect_ex = 1'b0;
      cyc("refill", REFL, 1'b0);
      idle_inputs();
      cyc("refill_done", NONE, 1'b0);

      // Three wait cycles, released on the fourth.
      dmem_req_mem = 1'b1;
      for (int i = 0; i < 3; i++) cyc("wait3", FRZ, 1'b0);
      dmem_ready = 1'b1;
      cyc("wait3_release", NONE, 1'b0);
      idle_inputs();
      cyc("wait3_after", NONE, 1'b0);

      // Timeout: four waiting cycles, the fourth abandons the access.
      dmem_req_mem = 1'b1;
      for (int i = 0; i < 3; i++) cyc("tmo_wait", FRZ, 1'b0);
      cyc("tmo_abort", ABORT, 1'b0);
      idle_inputs();
      cyc("tmo_err", NONE, 1'b1);
      cyc("tmo_err_clear", NONE, 1'b0);

      // Redirect and mem-wait together: freeze wins; reset in MEM_WAIT.
      dmem_req_mem = 1'b1;
      redirect_ex  = 1'b1;
      cyc("redir_vs_wait", FRZ, 1'b0);
      redirect_ex  = 1'b0;
      cyc("wait_hold", FRZ, 1'b0);
      rst = 1'b1;
      cyc("rst_in_wait", RSTV, 1'b0);
      rst = 1'b0;
      idle_inputs();
      cyc("post_rst_run", NONE, 1'b0);

      // Mem-wait during REFILL: freeze, and no REFILL after release.
      redirect_ex = 1'b1;
      cyc("redir2", REDIR, 1'b0);
      redirect_ex  = 1'b0;
      dmem_req_mem = 1'b1;
      cyc("refill_vs_wait", FRZ, 1'b0);
      dmem_ready = 1'b1;
      cyc("refill_wait_rel", NONE, 1'b0);
      idle_inputs();
      cyc("no_refill", NONE, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
